// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues pipelined in-order requests to
// instruction memory and buffers {pc, instr} pairs in a DEPTH-entry queue for decode.
module fetch_queue #(
    parameter int                 PC_SIZE  = 32,
    parameter int                 INSTR_W  = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [PC_SIZE-1:0] redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_SIZE-1:0] imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_SIZE-1:0] if_pc
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]    DEPTH_W = (CNT_W + 1)'(DEPTH);

    logic [PC_SIZE-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]   alloc_ptr_q, alloc_ptr_d;
    logic [PTR_W-1:0]   fill_ptr_q, fill_ptr_d;
    logic [PTR_W-1:0]   head_ptr_q, head_ptr_d;
    logic [CNT_W-1:0]   alloc_cnt_q, alloc_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    // Allocated-but-unfilled entries: the responses that must be dropped on a redirect.
    logic [CNT_W-1:0]   pend_cnt_q, pend_cnt_d;
    logic [DEPTH-1:0]   filled_q, filled_d;

    logic [PC_SIZE-1:0] ent_pc_q    [DEPTH];
    logic [INSTR_W-1:0] ent_instr_q [DEPTH];

    logic [CNT_W:0] occupancy;
    logic           accept;
    logic           pop;
    logic           rsp_fill;
    logic           rsp_drop;

    assign occupancy      = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};
    assign imem_req_valid = rst_n & fetch_en & ~redirect_valid & (occupancy < DEPTH_W);
    assign imem_req_addr  = pc_q;

    assign accept   = imem_req_valid & imem_req_ready;
    assign pop      = if_valid & if_ready;
    assign rsp_drop = imem_rsp_valid & (drop_cnt_q != '0);
    assign rsp_fill = imem_rsp_valid & (drop_cnt_q == '0) & ~redirect_valid;

    assign if_valid = filled_q[head_ptr_q];
    assign if_instr = ent_instr_q[head_ptr_q];
    assign if_pc    = ent_pc_q[head_ptr_q];

    always_comb begin
        pc_d        = pc_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;
        alloc_cnt_d = alloc_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        pend_cnt_d  = pend_cnt_q;
        filled_d    = filled_q;

        if (redirect_valid) begin
            // Any response this cycle is either already owed to drop_cnt or to an unfilled entry.
            pc_d        = redirect_pc & ~PC_SIZE'(3);
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            head_ptr_d  = '0;
            alloc_cnt_d = '0;
            pend_cnt_d  = '0;
            filled_d    = '0;
            drop_cnt_d  = drop_cnt_q + pend_cnt_q - CNT_W'(imem_rsp_valid);
        end else begin
            if (accept) begin
                alloc_ptr_d = alloc_ptr_q + PTR_W'(1);
                pc_d        = pc_q + PC_SIZE'(4);
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
            if (rsp_fill) begin
                filled_d[fill_ptr_q] = 1'b1;
                fill_ptr_d           = fill_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                filled_d[head_ptr_q] = 1'b0;
                head_ptr_d           = head_ptr_q + PTR_W'(1);
            end
            alloc_cnt_d = alloc_cnt_q + CNT_W'(accept) - CNT_W'(pop);
            pend_cnt_d  = pend_cnt_q + CNT_W'(accept) - CNT_W'(rsp_fill);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            alloc_cnt_q <= '0;
            drop_cnt_q  <= '0;
            pend_cnt_q  <= '0;
            filled_q    <= '0;
        end else begin
            pc_q        <= pc_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
            alloc_cnt_q <= alloc_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            pend_cnt_q  <= pend_cnt_d;
            filled_q    <= filled_d;
        end
    end

    // Payload storage carries no reset; the filled bits alone qualify it.
    always_ff @(posedge clk) begin
        if (accept) begin
            ent_pc_q[alloc_ptr_q] <= pc_q;
        end
        if (rsp_fill) begin
            ent_instr_q[fill_ptr_q] <= imem_rsp_data;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) (occupancy <= DEPTH_W));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table, directed corner sequences and random traffic,
// all compared against a queue-based reference model of the fetch front end.
module tb_fetch_queue;

    localparam int          PC_SIZE  = 32;
    localparam int          INSTR_W  = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    fetch_queue #(
        .PC_SIZE (PC_SIZE),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    typedef struct {
        bit          rst;
        bit          fe;
        bit          ir;
        bit          exp_rv;
        logic [31:0] exp_addr;
        bit          exp_iv;
        logic [31:0] exp_ipc;
    } vec_t;

    // Reference model: decoded words waiting for decode, requests awaiting data, drop debt.
    ent_t        m_rdy[$];
    logic [31:0] m_pend[$];
    int          m_drop;
    logic [31:0] m_pc;

    mreq_t mq[$];
    int    last_due;
    int    lat_min = 1;
    int    lat_max = 1;
    int    cyc;

    int checks   = 0;
    int failures = 0;

    logic        obs_rv;
    logic        obs_iv;
    logic [31:0] obs_addr;
    logic [31:0] obs_ipc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rdy.delete();
        m_pend.delete();
        m_drop   = 0;
        m_pc     = RESET_PC;
        mq.delete();
        last_due = -1;
        cyc      = 0;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b1;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        rst_n = 1'b1;
    endtask

    // One clock: drive the memory response, compare against the model, then advance both.
    task automatic do_cycle();
        bit    exp_rv;
        bit    exp_iv;
        bit    acc;
        bit    pop;
        bit    rsp;
        ent_t  e;
        mreq_t r;
        int    lat;
        int    due;

        rsp            = (mq.size() > 0) && (mq[0].due == cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mq[0].addr) : $urandom();
        #1;
        exp_rv = fetch_en && !redirect_valid && ((m_rdy.size() + m_pend.size() + m_drop) < DEPTH);
        exp_iv = (m_rdy.size() > 0);
        chk("req_valid", imem_req_valid, exp_rv);
        chk("req_addr", imem_req_addr, m_pc);
        chk("if_valid", if_valid, exp_iv);
        if (exp_iv) begin
            chk("if_pc", if_pc, m_rdy[0].pc);
            chk("if_instr", if_instr, m_rdy[0].instr);
        end
        obs_rv   = imem_req_valid;
        obs_addr = imem_req_addr;
        obs_iv   = if_valid;
        obs_ipc  = if_pc;

        if (rsp) r = mq.pop_front();
        if (imem_req_valid && imem_req_ready) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.due    = due;
            r.addr   = imem_req_addr;
            mq.push_back(r);
        end

        acc = exp_rv && imem_req_ready;
        pop = exp_iv && if_ready;
        if (redirect_valid) begin
            m_drop = m_drop + m_pend.size() - int'(rsp);
            m_rdy.delete();
            m_pend.delete();
            m_pc = redirect_pc & ~32'h3;
        end else begin
            if (pop) e = m_rdy.pop_front();
            if (rsp) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else if (m_pend.size() > 0) begin
                    e.pc    = m_pend.pop_front();
                    e.instr = imem_rsp_data;
                    m_rdy.push_back(e);
                end
            end
            if (acc) begin
                m_pend.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #2;
        cyc++;
    endtask

    function automatic vec_t mkv(bit rst, bit fe, bit ir, bit rv, logic [31:0] addr,
                                 bit iv, logic [31:0] ipc);
        vec_t t;
        t.rst      = rst;
        t.fe       = fe;
        t.ir       = ir;
        t.exp_rv   = rv;
        t.exp_addr = addr;
        t.exp_iv   = iv;
        t.exp_ipc  = ipc;
        return t;
    endfunction

    initial begin
        vec_t        tbl[$];
        logic [31:0] pcs[$];
        bit          found;
        logic [31:0] first_pc;

        // Streaming with decode always ready, then a fill-to-full with decode stalled.
        tbl.push_back(mkv(1, 0, 0, 0, 32'h0,   0, 32'h0));
        tbl.push_back(mkv(0, 1, 1, 1, 32'h100, 0, 32'h0));
        tbl.push_back(mkv(0, 1, 1, 1, 32'h104, 0, 32'h0));
        tbl.push_back(mkv(0, 1, 1, 1, 32'h108, 1, 32'h100));
        tbl.push_back(mkv(0, 1, 1, 1, 32'h10C, 1, 32'h104));
        tbl.push_back(mkv(0, 1, 1, 1, 32'h110, 1, 32'h108));
        tbl.push_back(mkv(0, 1, 1, 1, 32'h114, 1, 32'h10C));
        tbl.push_back(mkv(1, 0, 0, 0, 32'h0,   0, 32'h0));
        tbl.push_back(mkv(0, 1, 0, 1, 32'h100, 0, 32'h0));
        tbl.push_back(mkv(0, 1, 0, 1, 32'h104, 0, 32'h0));
        tbl.push_back(mkv(0, 1, 0, 1, 32'h108, 1, 32'h100));
        tbl.push_back(mkv(0, 1, 0, 1, 32'h10C, 1, 32'h100));
        tbl.push_back(mkv(0, 1, 0, 0, 32'h110, 1, 32'h100));
        tbl.push_back(mkv(0, 1, 1, 0, 32'h110, 1, 32'h100));
        tbl.push_back(mkv(0, 1, 0, 1, 32'h110, 1, 32'h104));
        tbl.push_back(mkv(0, 1, 0, 0, 32'h114, 1, 32'h104));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) begin
                do_reset();
                continue;
            end
            fetch_en       = tbl[i].fe;
            if_ready       = tbl[i].ir;
            redirect_valid = 1'b0;
            imem_req_ready = 1'b1;
            lat_min        = 1;
            lat_max        = 1;
            do_cycle();
            chk($sformatf("tbl%0d_req_valid", i), obs_rv, tbl[i].exp_rv);
            chk($sformatf("tbl%0d_req_addr", i), obs_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_if_valid", i), obs_iv, tbl[i].exp_iv);
            if (tbl[i].exp_iv) chk($sformatf("tbl%0d_if_pc", i), obs_ipc, tbl[i].exp_ipc);
        end

        // Redirect with three requests in flight: drop debt of 3 leaves exactly one slot.
        do_reset();
        lat_min  = 5;
        lat_max  = 5;
        fetch_en = 1'b1;
        if_ready = 1'b1;
        for (int k = 0; k < 3; k++) do_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2002;
        do_cycle();
        chk("inflt_redir_no_req", obs_rv, 0);
        redirect_valid = 1'b0;
        do_cycle();
        chk("inflt_req_valid", obs_rv, 1);
        chk("inflt_req_addr", obs_addr, 32'h2000);
        do_cycle();
        chk("inflt_full", obs_rv, 0);
        do_cycle();
        chk("inflt_resume", obs_rv, 1);
        chk("inflt_resume_addr", obs_addr, 32'h2004);
        found    = 1'b0;
        first_pc = '0;
        for (int k = 0; k < 30 && !found; k++) begin
            do_cycle();
            if (obs_iv) begin
                found    = 1'b1;
                first_pc = obs_ipc;
            end
        end
        chk("inflt_first_seen", found, 1);
        chk("inflt_first_pc", first_pc, 32'h2000);

        // Redirect in the same cycle as a response and a decode pop.
        do_reset();
        lat_min  = 2;
        lat_max  = 2;
        fetch_en = 1'b1;
        if_ready = 1'b1;
        for (int k = 0; k < 4; k++) do_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000;
        do_cycle();
        chk("coinc_pop_valid", obs_iv, 1);
        chk("coinc_pop_pc", obs_ipc, 32'h104);
        redirect_valid = 1'b0;
        do_cycle();
        chk("coinc_if_valid_r1", obs_iv, 0);
        chk("coinc_req_addr_r1", obs_addr, 32'h3000);
        found    = 1'b0;
        first_pc = '0;
        for (int k = 0; k < 20 && !found; k++) begin
            do_cycle();
            if (obs_iv) begin
                found    = 1'b1;
                first_pc = obs_ipc;
            end
        end
        chk("coinc_first_seen", found, 1);
        chk("coinc_first_pc", first_pc, 32'h3000);

        // PC wrap at the top of the address space.
        do_reset();
        lat_min  = 1;
        lat_max  = 1;
        fetch_en = 1'b1;
        if_ready = 1'b1;
        do_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        do_cycle();
        redirect_valid = 1'b0;
        do_cycle();
        chk("wrap_addr0", obs_addr, 32'hFFFF_FFFC);
        do_cycle();
        chk("wrap_addr1", obs_addr, 32'h0);
        chk("wrap_valid1", obs_rv, 1);
        pcs.delete();
        for (int k = 0; k < 20 && pcs.size() < 2; k++) begin
            do_cycle();
            if (obs_iv) pcs.push_back(obs_ipc);
        end
        chk("wrap_pc_count", pcs.size(), 2);
        if (pcs.size() == 2) begin
            chk("wrap_if_pc0", pcs[0], 32'hFFFF_FFFC);
            chk("wrap_if_pc1", pcs[1], 32'h0);
        end

        // fetch_en dropped with two requests outstanding.
        do_reset();
        lat_min  = 3;
        lat_max  = 3;
        fetch_en = 1'b1;
        if_ready = 1'b1;
        do_cycle();
        do_cycle();
        fetch_en = 1'b0;
        pcs.delete();
        for (int k = 0; k < 8; k++) begin
            do_cycle();
            chk($sformatf("gate_no_req%0d", k), obs_rv, 0);
            if (obs_iv) pcs.push_back(obs_ipc);
        end
        chk("gate_drained", pcs.size(), 2);
        if (pcs.size() == 2) begin
            chk("gate_if_pc0", pcs[0], 32'h100);
            chk("gate_if_pc1", pcs[1], 32'h104);
        end
        fetch_en = 1'b1;
        do_cycle();
        chk("gate_resume_valid", obs_rv, 1);
        chk("gate_resume_addr", obs_addr, 32'h108);

        // Random traffic with variable memory latency, redirects and one mid-run reset.
        do_reset();
        lat_min = 1;
        lat_max = 4;
        for (int n = 0; n < 4000; n++) begin
            if (n == 2000) do_reset();
            fetch_en       = ($urandom_range(9, 0) < 8);
            if_ready       = ($urandom_range(9, 0) < 7);
            imem_req_ready = ($urandom_range(9, 0) < 7);
            redirect_valid = ($urandom_range(19, 0) == 0);
            redirect_pc    = $urandom();
            do_cycle();
        end
        redirect_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
